// File: rtl/fetch_stage.sv
// fetch_stage: LoongArch instruction-fetch stage. Issues one SRAM-like read
// at a time, buffers {inst, pc} for decode, and redirects on br_taken.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   ds_allowin          decode can accept the held instruction this cycle
//   br_bus[32:0]        [32]=br_taken, [31:0]=br_target
//   fs_to_ds_valid      fs_to_ds_bus holds a valid instruction
//   fs_to_ds_bus[63:0]  [63:32]=inst, [31:0]=pc
//   inst_sram_req/addr  read request and its address (addr stable until addr_ok)
//   inst_sram_addr_ok   request accepted
//   inst_sram_data_ok   read data valid
//   inst_sram_rdata     read data
// Optional (macro FETCH_PERF_EN): perf_fetch_cnt, perf_discard_cnt.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [32:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_discard_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] req_addr;
    logic [31:0] redirect_pc;
    logic        stale;
    logic [31:0] inst_buf;
    logic [31:0] pc_buf;

    logic        br_taken;
    logic [31:0] br_target;

    logic        mark_stale;
    logic        take_inst;
    logic        discard;
    logic        drop_hold;
    logic        handoff;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    always_comb begin
        state_nxt  = state;
        mark_stale = 1'b0;
        take_inst  = 1'b0;
        discard    = 1'b0;
        drop_hold  = 1'b0;
        handoff    = 1'b0;
        unique case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
            end
            S_REQ: begin
                // Request already on the bus cannot be withdrawn; remember
                // the redirect and throw its response away later.
                mark_stale = br_taken;
                if (inst_sram_addr_ok) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (inst_sram_data_ok) begin
                    if (stale || br_taken) begin
                        discard   = 1'b1;
                        state_nxt = S_REQ;
                    end else begin
                        take_inst = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end else begin
                    mark_stale = br_taken;
                end
            end
            S_HOLD: begin
                // Decode drops its copy on br_taken too, so the branch
                // wins even if the handshake would complete.
                if (br_taken) begin
                    drop_hold = 1'b1;
                    state_nxt = S_REQ;
                end else if (ds_allowin) begin
                    handoff   = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            req_addr    <= RESET_PC;
            redirect_pc <= 32'd0;
            stale       <= 1'b0;
            inst_buf    <= 32'd0;
            pc_buf      <= 32'd0;
        end else begin
            state <= state_nxt;
            if (mark_stale) begin
                stale       <= 1'b1;
                redirect_pc <= br_target;
            end
            if (discard) begin
                stale    <= 1'b0;
                req_addr <= br_taken ? br_target : redirect_pc;
            end
            if (take_inst) begin
                inst_buf <= inst_sram_rdata;
                pc_buf   <= req_addr;
            end
            if (drop_hold) begin
                req_addr <= br_target;
            end
            if (handoff) begin
                req_addr <= pc_buf + 32'd4;
            end
        end
    end

    assign inst_sram_req  = (state == S_REQ);
    assign inst_sram_addr = req_addr;
    assign fs_to_ds_valid = (state == S_HOLD);
    assign fs_to_ds_bus   = {inst_buf, pc_buf};

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt   <= 32'd0;
            perf_discard_cnt <= 32'd0;
        end else begin
            if (handoff) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (discard || drop_hold) begin
                perf_discard_cnt <= perf_discard_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random checks of fetch_stage against a
// flag-level fetch model and a one-outstanding memory responder.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_allowin;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_discard_cnt;
`endif

    int checks = 0;
    int failures = 0;

    // reference model state
    bit          m_boot;
    bit          m_issuing;
    bit          m_inflight;
    bit          m_holding;
    bit          m_drop;
    logic [31:0] m_fetch_pc;
    logic [31:0] m_target;
    logic [31:0] m_hold_inst;
    logic [31:0] m_hold_pc;
    logic [31:0] m_fetch_cnt;
    logic [31:0] m_disc_cnt;
    bit          mem_pending;

    fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ds_allowin        (ds_allowin),
        .br_bus            (br_bus),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_discard_cnt  (perf_discard_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("req", {63'd0, inst_sram_req}, {63'd0, m_issuing});
        chk("valid", {63'd0, fs_to_ds_valid}, {63'd0, m_holding});
        chk("bus", fs_to_ds_bus, {m_hold_inst, m_hold_pc});
        if (m_issuing)
            chk("addr", {32'd0, inst_sram_addr}, {32'd0, m_fetch_pc});
`ifdef FETCH_PERF_EN
        chk("perf_fetch", {32'd0, perf_fetch_cnt}, {32'd0, m_fetch_cnt});
        chk("perf_disc", {32'd0, perf_discard_cnt}, {32'd0, m_disc_cnt});
`endif
    endtask

    task automatic model_reset();
        m_boot      = 1'b1;
        m_issuing   = 1'b0;
        m_inflight  = 1'b0;
        m_holding   = 1'b0;
        m_drop      = 1'b0;
        m_fetch_pc  = 32'h1c000000;
        m_target    = 32'd0;
        m_hold_inst = 32'd0;
        m_hold_pc   = 32'd0;
        m_fetch_cnt = 32'd0;
        m_disc_cnt  = 32'd0;
        mem_pending = 1'b0;
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        chk("rst_req", {63'd0, inst_sram_req}, 64'd0);
        chk("rst_valid", {63'd0, fs_to_ds_valid}, 64'd0);
        chk("rst_bus", fs_to_ds_bus, 64'd0);
        reset = 1'b0;
    endtask

    // One clock of stimulus; addr_ok/data_ok are masked so the memory
    // never breaks the one-outstanding protocol.
    task automatic step(input logic al, input logic br, input logic [31:0] tgt,
                        input logic aok, input logic dok,
                        input logic [31:0] rd);
        logic a;
        logic d;
        ds_allowin        = al;
        br_bus            = {br, tgt};
        a                 = aok & inst_sram_req;
        d                 = dok & mem_pending;
        inst_sram_addr_ok = a;
        inst_sram_data_ok = d;
        inst_sram_rdata   = rd;
        @(posedge clk);
        if (m_boot) begin
            m_boot    = 1'b0;
            m_issuing = 1'b1;
        end else if (m_issuing) begin
            if (br) begin
                m_drop   = 1'b1;
                m_target = tgt;
            end
            if (a) begin
                m_issuing  = 1'b0;
                m_inflight = 1'b1;
            end
        end else if (m_inflight) begin
            if (d) begin
                m_inflight = 1'b0;
                if (m_drop || br) begin
                    m_fetch_pc = br ? tgt : m_target;
                    m_drop     = 1'b0;
                    m_issuing  = 1'b1;
                    m_disc_cnt = m_disc_cnt + 1;
                end else begin
                    m_hold_inst = rd;
                    m_hold_pc   = m_fetch_pc;
                    m_holding   = 1'b1;
                end
            end else if (br) begin
                m_drop   = 1'b1;
                m_target = tgt;
            end
        end else if (m_holding) begin
            if (br) begin
                m_fetch_pc = tgt;
                m_holding  = 1'b0;
                m_issuing  = 1'b1;
                m_disc_cnt = m_disc_cnt + 1;
            end else if (al) begin
                m_fetch_pc  = m_hold_pc + 32'd4;
                m_holding   = 1'b0;
                m_issuing   = 1'b1;
                m_fetch_cnt = m_fetch_cnt + 1;
            end
        end
        if (a) mem_pending = 1'b1;
        else if (d) mem_pending = 1'b0;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        logic [31:0] t;
        ds_allowin      = 1'b0;
        br_bus          = 33'd0;
        inst_sram_rdata = 32'd0;
        do_reset();

        // basic fetch
        step(1, 0, 0, 1, 0, 0);
        chk("first_addr", {32'd0, inst_sram_addr}, 64'h1c000000);
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 32'h02800421);
        chk("first_bus", fs_to_ds_bus, 64'h02800421_1c000000);
        step(1, 0, 0, 0, 0, 0);
        chk("pc4_addr", {32'd0, inst_sram_addr}, 64'h1c000004);

        // decode stalls in S_HOLD
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 32'h03400000);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 1, 0);
            chk("stall_bus", fs_to_ds_bus, 64'h03400000_1c000004);
        end
        step(1, 0, 0, 0, 0, 0);
        chk("stall_next", {32'd0, inst_sram_addr}, 64'h1c000008);

        // branch while waiting for data
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 32'h1c000100, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'hdeadbeef);
        chk("wait_br_valid", {63'd0, fs_to_ds_valid}, 64'd0);
        chk("wait_br_addr", {32'd0, inst_sram_addr}, 64'h1c000100);

        // branch while request not yet accepted
        step(0, 1, 32'h1c000200, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("req_br_hold", {32'd0, inst_sram_addr}, 64'h1c000100);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 32'h12345678);
        chk("req_br_addr", {32'd0, inst_sram_addr}, 64'h1c000200);

        // branch and allowin together in S_HOLD
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0badf00d);
        step(1, 1, 32'h1c000300, 0, 0, 0);
        chk("hold_br_addr", {32'd0, inst_sram_addr}, 64'h1c000300);

        // pc+4 wraps at 2^32
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 32'hfffffffc, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0000_0001);
        chk("wrap_bus", fs_to_ds_bus, 64'h00000001_fffffffc);
        step(1, 0, 0, 0, 0, 0);
        chk("wrap_addr", {32'd0, inst_sram_addr}, 64'h0);

        // reset while waiting for data
        step(0, 0, 0, 1, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 0, 0);
        chk("post_rst_addr", {32'd0, inst_sram_addr}, 64'h1c000000);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            t = ($urandom_range(0, 7) == 0) ? 32'hfffffffc
                                            : {$urandom_range(0, 32'h3fffffff), 2'b00};
            step($urandom_range(0, 1), ($urandom_range(0, 5) == 0), t,
                 $urandom_range(0, 1), ($urandom_range(0, 2) != 0), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
